// File: rtl/input_unit_xy_if.sv
// Link bundle for one router input port: the req/ack flit link from the
// upstream router and the switch request / flit stream toward the crossbar.
// The slave modport is the input unit's view; master is the environment's.
interface input_unit_xy_if #(
  parameter int FLIT_W       = 34,
  parameter int NUM_OF_PORTS = 5
);
  logic                    i_upstream_req;
  logic [FLIT_W-1:0]       i_flit;
  logic                    o_upstream_ack;
  logic [NUM_OF_PORTS-1:0] o_switch_req;
  logic [NUM_OF_PORTS-1:0] i_switch_ack;
  logic                    o_flit_valid;
  logic [FLIT_W-1:0]       o_flit;
  logic                    o_empty;
  logic                    o_full;

  modport slave (
    input  i_upstream_req, i_flit, i_switch_ack,
    output o_upstream_ack, o_switch_req, o_flit_valid, o_flit, o_empty, o_full
  );

  modport master (
    output i_upstream_req, i_flit, i_switch_ack,
    input  o_upstream_ack, o_switch_req, o_flit_valid, o_flit, o_empty, o_full
  );
endinterface

// File: rtl/input_unit_xy.sv
// Router input unit: captures flits from the upstream link into a small
// circular FIFO, XY-routes each packet head, requests one output port and
// streams the packet to the crossbar while granted.
// Optional statistics counters (flits forwarded, orphans dropped) are
// compiled in when IU_STATS_EN is defined.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for a HEAD/HEAD_TAIL at the FIFO head; orphans dropped
// ROUTE      | one cycle: compute and register the XY output port
// WAIT_GRANT | one-hot switch request held until the matching grant bit
// ACTIVE     | streaming FIFO head to crossbar until the tail is popped
module input_unit_xy #(
  parameter int FLIT_W       = 34,
  parameter int COORD_W      = 4,
  parameter int DEPTH        = 4,
  parameter int NUM_OF_PORTS = 5,
  parameter int MY_X         = 0,
  parameter int MY_Y         = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input_unit_xy_if.slave  bus
`ifdef IU_STATS_EN
  ,
  output logic [31:0]     o_flit_cnt,
  output logic [15:0]     o_drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  localparam int PORT_LOCAL = 0;
  localparam int PORT_NORTH = 1;
  localparam int PORT_EAST  = 2;
  localparam int PORT_SOUTH = 3;
  localparam int PORT_WEST  = 4;

  localparam logic [COORD_W-1:0] MY_X_C = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] MY_Y_C = COORD_W'(MY_Y);
  localparam logic [AW:0]        FULL_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ROUTE,
    WAIT_GRANT,
    ACTIVE
  } state_e;

  // FIFO storage and pointers
  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              ack_q;

  // control
  state_e                  state_q;
  logic [NUM_OF_PORTS-1:0] switch_req_q;

  // head-of-FIFO decode
  logic [FLIT_W-1:0]  head_flit;
  logic [1:0]         head_type;
  logic [COORD_W-1:0] head_dx;
  logic [COORD_W-1:0] head_dy;
  logic               head_starts_pkt;
  logic               head_ends_pkt;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic pop_active;
  logic pop_orphan;

  // XY dimension-order routing: resolve X first, then Y, else local.
  function automatic logic [NUM_OF_PORTS-1:0] xy_route(
    input logic [COORD_W-1:0] dx,
    input logic [COORD_W-1:0] dy
  );
    logic [NUM_OF_PORTS-1:0] req;
    req = '0;
    if (dx > MY_X_C)      req[PORT_EAST]  = 1'b1;
    else if (dx < MY_X_C) req[PORT_WEST]  = 1'b1;
    else if (dy > MY_Y_C) req[PORT_NORTH] = 1'b1;
    else if (dy < MY_Y_C) req[PORT_SOUTH] = 1'b1;
    else                  req[PORT_LOCAL] = 1'b1;
    return req;
  endfunction

  assign head_flit = mem_q[rd_ptr_q];
  assign head_type = head_flit[FLIT_W-1 -: 2];
  assign head_dx   = head_flit[FLIT_W-3 -: COORD_W];
  assign head_dy   = head_flit[FLIT_W-3-COORD_W -: COORD_W];

  // type[1] set means HEAD or HEAD_TAIL; type[0] set means TAIL or HEAD_TAIL
  assign head_starts_pkt = head_type[1];
  assign head_ends_pkt   = head_type[0];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_C);

  // ack_q blocks a second capture of the flit the upstream is still holding
  assign push       = bus.i_upstream_req & ~fifo_full & ~ack_q;
  assign pop_active = (state_q == ACTIVE) & ~fifo_empty;
  assign pop_orphan = (state_q == IDLE) & ~fifo_empty & ~head_starts_pkt;
  assign pop        = pop_active | pop_orphan;

  // Next-state of the FIFO bookkeeping; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, occupancy and the one-cycle upstream ack pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ack_q    <= push;
    end
  end

  // Flit storage; contents need no reset since occupancy gates all reads
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.i_flit;
    end
  end

  // Packet sequencing: route, request, stream, release on tail
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      switch_req_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty && head_starts_pkt) begin
            state_q <= ROUTE;
          end
        end
        ROUTE: begin
          switch_req_q <= xy_route(head_dx, head_dy);
          state_q      <= WAIT_GRANT;
        end
        WAIT_GRANT: begin
          if (|(bus.i_switch_ack & switch_req_q)) begin
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (pop_active && head_ends_pkt) begin
            state_q      <= IDLE;
            switch_req_q <= '0;
          end
        end
        default: begin
          state_q      <= IDLE;
          switch_req_q <= '0;
        end
      endcase
    end
  end

  assign bus.o_upstream_ack = ack_q;
  assign bus.o_switch_req   = switch_req_q;
  assign bus.o_flit_valid   = pop_active;
  assign bus.o_flit         = pop_active ? head_flit : '0;
  assign bus.o_empty        = fifo_empty;
  assign bus.o_full         = fifo_full;

`ifdef IU_STATS_EN
  logic [31:0] flit_cnt_q;
  logic [15:0] drop_cnt_q;

  // Forwarded-flit counter wraps; orphan-drop counter saturates
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flit_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (pop_active) begin
        flit_cnt_q <= flit_cnt_q + 32'd1;
      end
      if (pop_orphan && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign o_flit_cnt = flit_cnt_q;
  assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_input_unit_xy.sv
// Directed bench for input_unit_xy at router (1,1), DEPTH 4.
// A routing table drives single-flit packets; hand-written sequences cover
// multi-flit packets, FIFO-full stall, orphan drops and mid-packet reset.
module tb_input_unit_xy;
  localparam int FLIT_W  = 34;
  localparam int COORD_W = 4;
  localparam int DEPTH   = 4;
  localparam int NP      = 5;

  localparam logic [1:0] T_HEAD = 2'b10;
  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b01;
  localparam logic [1:0] T_HT   = 2'b11;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  input_unit_xy_if #(.FLIT_W(FLIT_W), .NUM_OF_PORTS(NP)) bus ();

`ifdef IU_STATS_EN
  logic [31:0] flit_cnt;
  logic [15:0] drop_cnt;
`endif

  input_unit_xy #(
    .FLIT_W(FLIT_W), .COORD_W(COORD_W), .DEPTH(DEPTH),
    .NUM_OF_PORTS(NP), .MY_X(1), .MY_Y(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
`ifdef IU_STATS_EN
    ,
    .o_flit_cnt(flit_cnt),
    .o_drop_cnt(drop_cnt)
`endif
  );

  typedef struct {
    logic [3:0] dx;
    logic [3:0] dy;
    logic [4:0] exp_req;
    logic [4:0] bad_ack;
  } vec_t;

  vec_t vecs[10];
  logic [FLIT_W-1:0] pk[8];

  int n_vec  = 0;
  int n_fail = 0;
  int exp_flits = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL timeout %s: wait bound expired", name);
  endtask

  function automatic logic [FLIT_W-1:0] mk_flit(input logic [1:0] t, input logic [3:0] dx,
                                                input logic [3:0] dy, input logic [23:0] pay);
    return {t, dx, dy, pay};
  endfunction

  // Present one flit and hold req until the ack pulse is seen (at a negedge)
  task automatic send_flit(input logic [FLIT_W-1:0] f);
    bit got;
    got = 1'b0;
    bus.i_flit = f;
    bus.i_upstream_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.o_upstream_ack) begin
        got = 1'b1;
        break;
      end
    end
    bus.i_upstream_req = 1'b0;
    if (!got) timeout("upstream ack");
  endtask

  task automatic wait_req(output int cyc);
    cyc = 0;
    while (bus.o_switch_req == '0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.o_switch_req == '0) timeout("switch_req");
  endtask

  // Collect n flits from the crossbar side and compare against pk[]
  task automatic collect(input int n, input string name);
    int k;
    k = 0;
    for (int c = 0; c < 40 && k < n; c++) begin
      @(negedge clk);
      if (bus.o_flit_valid) begin
        check(name, 64'(bus.o_flit), 64'(pk[k]));
        k++;
      end
    end
    if (k != n) timeout(name);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " ack"},   64'(bus.o_upstream_ack), 64'd0);
    check({name, " req"},   64'(bus.o_switch_req),   64'd0);
    check({name, " valid"}, 64'(bus.o_flit_valid),   64'd0);
    check({name, " flit"},  64'(bus.o_flit),         64'd0);
    check({name, " empty"}, 64'(bus.o_empty),        64'd1);
    check({name, " full"},  64'(bus.o_full),         64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int seen;
    int up;
    int k;
    logic [FLIT_W-1:0] f;

    // dx, dy, expected one-hot request, wrong-bit ack applied first
    vecs[0] = '{4'd3,  4'd1,  5'b00100, 5'b00000};
    vecs[1] = '{4'd1,  4'd1,  5'b00001, 5'b00010};
    vecs[2] = '{4'd0,  4'd1,  5'b10000, 5'b00001};
    vecs[3] = '{4'd1,  4'd2,  5'b00010, 5'b00000};
    vecs[4] = '{4'd1,  4'd0,  5'b01000, 5'b10100};
    vecs[5] = '{4'd0,  4'd5,  5'b10000, 5'b00000};
    vecs[6] = '{4'd2,  4'd0,  5'b00100, 5'b01000};
    vecs[7] = '{4'd1,  4'd15, 5'b00010, 5'b00000};
    vecs[8] = '{4'd15, 4'd15, 5'b00100, 5'b00000};
    vecs[9] = '{4'd0,  4'd0,  5'b10000, 5'b00000};

    bus.i_upstream_req = 1'b0;
    bus.i_flit = '0;
    bus.i_switch_ack = '0;

    // reset state
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post-reset");

    // single-flit packets through the routing table
    for (int i = 0; i < 10; i++) begin
      f = mk_flit(T_HT, vecs[i].dx, vecs[i].dy, 24'(24'hA00000 + i));
      send_flit(f);
      wait_req(cyc);
      check("route latency", 64'(cyc), 64'd2);
      check("route req", 64'(bus.o_switch_req), 64'(vecs[i].exp_req));
      check("valid before grant", 64'(bus.o_flit_valid), 64'd0);
      if (vecs[i].bad_ack != '0) begin
        bus.i_switch_ack = vecs[i].bad_ack;
        repeat (3) @(negedge clk);
        check("req held on wrong ack", 64'(bus.o_switch_req), 64'(vecs[i].exp_req));
        check("no valid on wrong ack", 64'(bus.o_flit_valid), 64'd0);
      end
      bus.i_switch_ack = vecs[i].exp_req;
      @(negedge clk);
      check("ht valid", 64'(bus.o_flit_valid), 64'd1);
      check("ht flit", 64'(bus.o_flit), 64'(f));
      bus.i_switch_ack = '0;
      @(negedge clk);
      check("ht valid one cycle", 64'(bus.o_flit_valid), 64'd0);
      check("ht req released", 64'(bus.o_switch_req), 64'd0);
      check("ht fifo empty", 64'(bus.o_empty), 64'd1);
    end
    exp_flits += 10;

    // 4-flit packet to (1,0) with a delayed grant
    pk[0] = mk_flit(T_HEAD, 4'd1, 4'd0, 24'h000111);
    pk[1] = mk_flit(T_BODY, 4'd7, 4'd7, 24'h000222);
    pk[2] = mk_flit(T_BODY, 4'd0, 4'd0, 24'h000333);
    pk[3] = mk_flit(T_TAIL, 4'd9, 4'd3, 24'h000444);
    for (int i = 0; i < 4; i++) send_flit(pk[i]);
    check("4f req", 64'(bus.o_switch_req), 64'b01000);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.o_flit_valid) seen++;
    end
    check("4f no valid before grant", 64'(seen), 64'd0);
    check("4f fifo occupied", 64'(bus.o_full), 64'd1);
    bus.i_switch_ack = 5'b01000;
    collect(4, "4f flit");
    bus.i_switch_ack = '0;
    @(negedge clk);
    check("4f req released", 64'(bus.o_switch_req), 64'd0);
    check("4f fifo empty", 64'(bus.o_empty), 64'd1);
    check("4f valid low", 64'(bus.o_flit_valid), 64'd0);
    exp_flits += 4;

    // FIFO full stall: 6 flits, no grant until the FIFO has filled
    pk[0] = mk_flit(T_HEAD, 4'd3, 4'd1, 24'h100000);
    for (int i = 1; i < 5; i++) pk[i] = mk_flit(T_BODY, 4'd0, 4'd0, 24'(24'h100000 + i));
    pk[5] = mk_flit(T_TAIL, 4'd0, 4'd0, 24'h1000FF);
    for (int i = 0; i < 4; i++) send_flit(pk[i]);
    check("full flag", 64'(bus.o_full), 64'd1);
    bus.i_flit = pk[4];
    bus.i_upstream_req = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.o_upstream_ack) seen++;
    end
    check("no ack while full", 64'(seen), 64'd0);
    check("still full", 64'(bus.o_full), 64'd1);
    check("full req east", 64'(bus.o_switch_req), 64'b00100);
    bus.i_switch_ack = 5'b00100;
    up = 4;
    k = 0;
    for (int c = 0; c < 60 && k < 6; c++) begin
      @(negedge clk);
      if (bus.o_flit_valid) begin
        check("stall flit", 64'(bus.o_flit), 64'(pk[k]));
        k++;
      end
      if (bus.o_upstream_ack) begin
        up++;
        if (up < 6) bus.i_flit = pk[up];
        else bus.i_upstream_req = 1'b0;
      end
    end
    bus.i_upstream_req = 1'b0;
    if (k != 6) timeout("stall drain");
    check("stall flits accepted", 64'(up), 64'd6);
    bus.i_switch_ack = '0;
    @(negedge clk);
    check("stall req released", 64'(bus.o_switch_req), 64'd0);
    check("stall fifo empty", 64'(bus.o_empty), 64'd1);
    exp_flits += 6;

    // orphan BODY then orphan TAIL at the head in IDLE
    send_flit(mk_flit(T_BODY, 4'd3, 4'd1, 24'h0BAD01));
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.o_flit_valid) seen++;
    end
    check("orphan body no valid", 64'(seen), 64'd0);
    check("orphan body popped", 64'(bus.o_empty), 64'd1);
    check("orphan body no req", 64'(bus.o_switch_req), 64'd0);
`ifdef IU_STATS_EN
    check("drop_cnt 1", 64'(drop_cnt), 64'd1);
`endif
    send_flit(mk_flit(T_TAIL, 4'd0, 4'd2, 24'h0BAD02));
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.o_flit_valid) seen++;
    end
    check("orphan tail no valid", 64'(seen), 64'd0);
    check("orphan tail popped", 64'(bus.o_empty), 64'd1);
`ifdef IU_STATS_EN
    check("drop_cnt 2", 64'(drop_cnt), 64'd2);
    check("flit_cnt", 64'(flit_cnt), 64'(exp_flits));
`endif

    // asynchronous reset in the middle of an ACTIVE packet
    pk[0] = mk_flit(T_HEAD, 4'd3, 4'd1, 24'h200001);
    pk[1] = mk_flit(T_BODY, 4'd0, 4'd0, 24'h200002);
    pk[2] = mk_flit(T_BODY, 4'd0, 4'd0, 24'h200003);
    for (int i = 0; i < 3; i++) send_flit(pk[i]);
    check("rst pkt req", 64'(bus.o_switch_req), 64'b00100);
    bus.i_switch_ack = 5'b00100;
    @(negedge clk);
    check("rst pkt head valid", 64'(bus.o_flit_valid), 64'd1);
    check("rst pkt head flit", 64'(bus.o_flit), 64'(pk[0]));
    bus.i_switch_ack = '0;
    #2 reset_n = 1'b0;
    #1;
    check_idle_outputs("async reset");
`ifdef IU_STATS_EN
    check("rst flit_cnt", 64'(flit_cnt), 64'd0);
    check("rst drop_cnt", 64'(drop_cnt), 64'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after reset release");

    // new packet routed normally after reset
    f = mk_flit(T_HT, 4'd1, 4'd2, 24'h300000);
    send_flit(f);
    wait_req(cyc);
    check("post-reset req north", 64'(bus.o_switch_req), 64'b00010);
    bus.i_switch_ack = 5'b00010;
    @(negedge clk);
    check("post-reset valid", 64'(bus.o_flit_valid), 64'd1);
    check("post-reset flit", 64'(bus.o_flit), 64'(f));
    bus.i_switch_ack = '0;
    @(negedge clk);
    check("post-reset released", 64'(bus.o_switch_req), 64'd0);
    check("post-reset empty", 64'(bus.o_empty), 64'd1);
`ifdef IU_STATS_EN
    check("post-reset flit_cnt", 64'(flit_cnt), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
